// File: rtl/tt_check_pkg.sv
// Shared types and constants for the truth-table sweep checker.
// State encoding, default sizing and the expected-table width helper.
package tt_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tt_state_e;

    localparam int TT_N_IN_DEF   = 2;
    localparam int TT_SETTLE_DEF = 1;

    function automatic int tt_tbl_w(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that times the settle hold of each minterm.
// zero: count is idle; expire: the decrement this cycle reaches zero.
module tt_settle_timer
    import tt_check_pkg::*;
#(
    parameter int SETTLE = TT_SETTLE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic zero,
    output logic expire
);

    localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(SETTLE);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero   = (cnt_q == '0);
    assign expire = (cnt_q == CW'(1));

endmodule

// File: rtl/tt_sweep_checker.sv
// Clocked truth-table sweep comparing two implementations of one function.
// Define TT_CHECK_EXPECTED_EN to also check implementation A against EXPECT.
module tt_sweep_checker
    import tt_check_pkg::*;
#(
    parameter int                            N_IN   = TT_N_IN_DEF,
    parameter int                            SETTLE = TT_SETTLE_DEF,
    parameter logic [tt_tbl_w(N_IN)-1:0]     EXPECT = 4'b0010
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [N_IN-1:0] dut_x,
    input  logic            dut_a,
    input  logic            dut_b,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail
);

    localparam logic [N_IN-1:0] X_MAX    = '1;
    localparam tt_state_e       FIRST_ST = (SETTLE == 0) ? ST_SAMPLE : ST_DRIVE;

    tt_state_e       state_q, state_d;
    logic [N_IN-1:0] x_q, x_d;
    logic [N_IN:0]   err_q, err_d;
    logic            fv_q, fv_d;
    logic [N_IN-1:0] ff_q, ff_d;
    logic            pass_q, pass_d;
    logic            tmr_load, tmr_zero, tmr_expire;
    logic            mis;

    tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (tmr_load),
        .zero   (tmr_zero),
        .expire (tmr_expire)
    );

    // XOR against 0 with !== flags X/Z on either output as a mismatch in 4-state sim.
`ifdef TT_CHECK_EXPECTED_EN
    assign mis = ((dut_a ^ dut_b) !== 1'b0) || ((dut_a ^ EXPECT[x_q]) !== 1'b0);
`else
    logic unused_expect;
    assign unused_expect = ^EXPECT;
    assign mis = ((dut_a ^ dut_b) !== 1'b0);
`endif

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        err_d    = err_q;
        fv_d     = fv_q;
        ff_d     = ff_q;
        pass_d   = pass_q;
        tmr_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = FIRST_ST;
                    x_d      = '0;
                    err_d    = '0;
                    fv_d     = 1'b0;
                    ff_d     = '0;
                    pass_d   = 1'b0;
                    tmr_load = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (tmr_expire || tmr_zero) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (mis) begin
                    err_d = err_q + (N_IN+1)'(1);
                    if (!fv_q) begin
                        ff_d = x_q;
                        fv_d = 1'b1;
                    end
                end
                if (x_q == X_MAX) begin
                    state_d = ST_DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    x_d      = x_q + N_IN'(1);
                    tmr_load = 1'b1;
                    state_d  = FIRST_ST;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ff_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            ff_q    <= ff_d;
            pass_q  <= pass_d;
        end
    end

    assign dut_x      = x_q;
    assign busy       = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign done       = (state_q == ST_DONE);
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: a SETTLE=1 and a SETTLE=0 instance driven by
// truth tables, results checked against a per-minterm reference model.
module tb_tt_sweep_checker;

    localparam logic [3:0] EXP_TBL = 4'b0010;

    logic       clk = 1'b0;
    logic       reset, start, sel;
    logic [3:0] tbl_a, tbl_b;
    logic       start_a, start_b;

    logic [1:0] x_a, x_b, ff_a, ff_b;
    logic [2:0] err_a, err_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b, fv_a, fv_b;

    logic [1:0] o_x, o_ff;
    logic [2:0] o_err;
    logic       o_busy, o_done, o_pass, o_fv;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    tt_sweep_checker #(.N_IN(2), .SETTLE(1), .EXPECT(EXP_TBL)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .dut_x(x_a),
        .dut_a(tbl_a[x_a]), .dut_b(tbl_b[x_a]), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .fail_valid(fv_a), .first_fail(ff_a)
    );

    tt_sweep_checker #(.N_IN(2), .SETTLE(0), .EXPECT(EXP_TBL)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .dut_x(x_b),
        .dut_a(tbl_a[x_b]), .dut_b(tbl_b[x_b]), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .fail_valid(fv_b), .first_fail(ff_b)
    );

    always_comb begin
        o_x    = sel ? x_b    : x_a;
        o_ff   = sel ? ff_b   : ff_a;
        o_err  = sel ? err_b  : err_a;
        o_busy = sel ? busy_b : busy_a;
        o_done = sel ? done_b : done_a;
        o_pass = sel ? pass_b : pass_a;
        o_fv   = sel ? fv_b   : fv_a;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Failure set straight from the mismatch rule, one minterm at a time.
    function automatic void model(input logic [3:0] ta, input logic [3:0] tbv,
                                  output int n_err, output int first);
        n_err = 0;
        first = -1;
        for (int m = 0; m < 4; m++) begin
            bit bad;
            bad = (ta[m] != tbv[m]);
`ifdef TT_CHECK_EXPECTED_EN
            if (ta[m] != EXP_TBL[m]) bad = 1'b1;
`endif
            if (bad) begin
                n_err++;
                if (first < 0) first = m;
            end
        end
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".busy"}, o_busy, 0);
        chk({tag, ".done"}, o_done, 0);
        chk({tag, ".pass"}, o_pass, 0);
        chk({tag, ".x"},    o_x,    0);
        chk({tag, ".err"},  o_err,  0);
        chk({tag, ".fv"},   o_fv,   0);
        chk({tag, ".ff"},   o_ff,   0);
    endtask

    task automatic sweep(input string tag, input bit s, input logic [3:0] ta,
                         input logic [3:0] tbv, input bit extra);
        int n_err, first, sp, lat, busy_cnt, done_cnt, exp_lat;
        sel   = s;
        tbl_a = ta;
        tbl_b = tbv;
        model(ta, tbv, n_err, first);
        sp       = s ? 0 : 1;
        exp_lat  = 4 * (sp + 1) + 1;
        lat      = 0;
        busy_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= exp_lat + 3; c++) begin
            @(negedge clk);
            start = extra && (c == 2 || c == 5);
            if (o_busy) begin
                busy_cnt++;
                chk({tag, ".x"}, o_x, (c - 1) / (sp + 1));
            end
            chk({tag, ".busy_and_done"}, o_busy & o_done, 0);
            if (o_done) begin
                done_cnt++;
                if (lat == 0) lat = c;
                chk({tag, ".pass"}, o_pass, (n_err == 0) ? 1 : 0);
                chk({tag, ".err"},  o_err,  n_err);
                chk({tag, ".fv"},   o_fv,   (n_err > 0) ? 1 : 0);
                chk({tag, ".ff"},   o_ff,   (n_err > 0) ? first : 0);
            end
        end
        start = 1'b0;
        chk({tag, ".latency"},  lat,      exp_lat);
        chk({tag, ".busy_cyc"}, busy_cnt, exp_lat - 1);
        chk({tag, ".done_cnt"}, done_cnt, 1);
        chk({tag, ".err_hold"}, o_err,    n_err);
        chk({tag, ".pass_hold"}, o_pass,  (n_err == 0) ? 1 : 0);
    endtask

    initial begin
        int d1, d2, nd;
        logic [3:0] ra, rb;
        bit rs;
        reset = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        tbl_a = '0;
        tbl_b = '0;
        repeat (3) @(negedge clk);
        sel = 1'b0;
        chk_idle_outputs("rst_a");
        sel = 1'b1;
        chk_idle_outputs("rst_b");
        reset = 1'b0;

        // ~x1&x0 against itself, then against its complement, then x1&x0 twice
        sweep("eq_a",   1'b0, 4'b0010, 4'b0010, 1'b0);
        sweep("cmpl_a", 1'b0, 4'b0010, 4'b1101, 1'b0);
        sweep("and_a",  1'b0, 4'b1000, 4'b1000, 1'b0);
        sweep("eq_b",   1'b1, 4'b0010, 4'b0010, 1'b0);
        sweep("cmpl_b", 1'b1, 4'b0010, 4'b1101, 1'b0);
        sweep("and_b",  1'b1, 4'b1000, 4'b1000, 1'b0);
        sweep("ign_a",  1'b0, 4'b0110, 4'b0100, 1'b1);

        // reset in the fourth cycle of a failing sweep discards the partial result
        sel   = 1'b0;
        tbl_a = 4'b0010;
        tbl_b = 4'b1101;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        chk_idle_outputs("midrst");
        reset = 1'b0;
        sweep("post_rst", 1'b0, 4'b0010, 4'b0010, 1'b0);

        // start held high: second sweep begins on the IDLE cycle after done
        sel   = 1'b0;
        d1    = 0;
        d2    = 0;
        nd    = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (c == 19) start = 1'b0;
            if (o_done) begin
                nd++;
                if (d1 == 0) d1 = c;
                else if (d2 == 0) d2 = c;
            end
        end
        start = 1'b0;
        chk("held.ndone", nd, 2);
        chk("held.d1",    d1, 9);
        chk("held.d2",    d2, 19);

        for (int i = 0; i < 8; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = 4'($urandom_range(0, 15));
            rb = ($urandom_range(0, 1) == 1) ? ra : 4'($urandom_range(0, 15));
            sweep("rnd", rs, ra, rb, 1'($urandom_range(0, 1)) & ~rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
